// File: rtl/pll_clk_sequencer.sv
// PLL bring-up sequencer: pulses the PLL reset, filters a synchronized lock,
// staggers per-channel clock enables, then releases channel domain resets.
module pll_clk_sequencer #(
  parameter int NCH          = 5,
  parameter int LOCK_FILT    = 16,
  parameter int STAGGER      = 8,
  parameter int RST_DLY      = 4,
  parameter int PLL_RST_CYC  = 16,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int CNT_W        = 8
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             lock,
  input  logic [NCH-1:0]   ch_mask,
  output logic             pll_rst,
  output logic [NCH-1:0]   enclk,
  output logic [NCH-1:0]   rst_out,
  output logic             ready,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] relock_cnt
);

  localparam int MAX_A   = (LOCK_FILT > STAGGER) ? LOCK_FILT : STAGGER;
  localparam int MAX_B   = (RST_DLY > PLL_RST_CYC) ? RST_DLY : PLL_RST_CYC;
  localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_CYC = (MAX_C > LOCK_TIMEOUT) ? MAX_C : LOCK_TIMEOUT;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [TW-1:0] T_PLL  = TW'(PLL_RST_CYC - 1);
  localparam logic [TW-1:0] T_TO   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] T_FILT = TW'(LOCK_FILT - 1);
  localparam logic [TW-1:0] T_STAG = TW'(STAGGER - 1);
  localparam logic [TW-1:0] T_RDLY = TW'(RST_DLY - 1);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_FILTER    = 3'd2,
    S_ENABLE    = 3'd3,
    S_RELEASE   = 3'd4,
    S_RUN       = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CHW-1:0]   ch_q, ch_d;
  logic [NCH-1:0]   mask_q, mask_d;
  logic [NCH-1:0]   enclk_q, enclk_d;
  logic [NCH-1:0]   rst_out_q, rst_out_d;
  logic             ready_q, ready_d;
  logic [CNT_W-1:0] relock_q, relock_d;
  logic             lock_meta_q, lock_meta_d;
  logic             lock_s_q, lock_s_d;

  logic             nxt_found;
  logic [CHW-1:0]   nxt_idx;
  logic [NCH-1:0]   search_mask;
  int               search_lo;
  logic             lock_lost;

  // Next used channel: lowest set bit at or above search_lo; masked channels cost no cycles.
  always_comb begin
    search_mask = (state_q == S_FILTER) ? ch_mask : mask_q;
    search_lo   = (state_q == S_FILTER) ? 0 : int'(ch_q) + 1;
    nxt_found   = 1'b0;
    nxt_idx     = '0;
    for (int j = NCH - 1; j >= 0; j--) begin
      if (search_mask[j] && (j >= search_lo)) begin
        nxt_found = 1'b1;
        nxt_idx   = CHW'(j);
      end
    end
  end

  always_comb begin
    lock_meta_d = lock;
    lock_s_d    = lock_meta_q;
    state_d     = state_q;
    timer_d     = timer_q;
    ch_d        = ch_q;
    mask_d      = mask_q;
    enclk_d     = enclk_q;
    rst_out_d   = rst_out_q;
    ready_d     = ready_q;
    relock_d    = relock_q;
    lock_lost   = !lock_s_q &&
                  ((state_q == S_ENABLE) || (state_q == S_RELEASE) || (state_q == S_RUN));

    case (state_q)
      S_PLL_RST: begin
        enclk_d   = '0;
        rst_out_d = '1;
        ready_d   = 1'b0;
        if (timer_q == T_PLL) begin
          state_d = S_WAIT_LOCK;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d = S_FILTER;
          timer_d = '0;
        end else if (timer_q == T_TO) begin
          state_d = S_PLL_RST;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_FILTER: begin
        if (!lock_s_q) begin
          state_d = S_WAIT_LOCK;
          timer_d = '0;
        end else if (timer_q == T_FILT) begin
          mask_d  = ch_mask;
          timer_d = '0;
          if (nxt_found) begin
            state_d          = S_ENABLE;
            ch_d             = nxt_idx;
            enclk_d[nxt_idx] = 1'b1;
          end else begin
            state_d = S_RELEASE;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_ENABLE: begin
        if (timer_q == T_STAG) begin
          timer_d = '0;
          if (nxt_found) begin
            ch_d             = nxt_idx;
            enclk_d[nxt_idx] = 1'b1;
          end else begin
            state_d = S_RELEASE;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RELEASE: begin
        if (timer_q == T_RDLY) begin
          rst_out_d = ~mask_q;
          ready_d   = 1'b1;
          state_d   = S_RUN;
          timer_d   = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RUN: begin
      end
      default: begin
        state_d = S_PLL_RST;
        timer_d = '0;
      end
    endcase

    // Lock loss overrides any slot or release progress on the same edge.
    if (lock_lost) begin
      state_d   = S_WAIT_LOCK;
      timer_d   = '0;
      enclk_d   = '0;
      rst_out_d = '1;
      ready_d   = 1'b0;
      if (relock_q != '1) begin
        relock_d = relock_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      state_q     <= S_PLL_RST;
      timer_q     <= '0;
      ch_q        <= '0;
      mask_q      <= '0;
      enclk_q     <= '0;
      rst_out_q   <= '1;
      ready_q     <= 1'b0;
      relock_q    <= '0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      ch_q        <= ch_d;
      mask_q      <= mask_d;
      enclk_q     <= enclk_d;
      rst_out_q   <= rst_out_d;
      ready_q     <= ready_d;
      relock_q    <= relock_d;
      lock_meta_q <= lock_meta_d;
      lock_s_q    <= lock_s_d;
    end
  end

  assign pll_rst    = (state_q == S_PLL_RST);
  assign state      = state_q;
  assign enclk      = enclk_q;
  assign rst_out    = rst_out_q;
  assign ready      = ready_q;
  assign relock_cnt = relock_q;

endmodule
